// File: rtl/led_pkg.sv
// Shared types and default timing constants for the LED arbiter.
package led_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_TICK_DIV = 25000000;
    localparam int DEF_PAT_W    = 8;

endpackage

// File: rtl/led_tick_gen.sv
// Bit-period prescaler: counts 0..TICK_DIV-1 while enabled, held at 0 otherwise.
module led_tick_gen
    import led_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = enable && (cnt_q == CNT_W'(TICK_DIV - 1));

    // Dropping enable clears the count on the same edge, so the next PLAY starts at 0.
    always_comb begin
        cnt_d = '0;
        if (enable && !tick) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_arbiter.sv
// Round-robin arbiter sharing one LED between NUM_REQ blink-pattern requesters.
// Define LED_ARB_ABORT_EN to let a requester cancel its pattern by dropping req.
module led_arbiter
    import led_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int PAT_W    = DEF_PAT_W
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*PAT_W-1:0] pattern,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     led_out,
    output logic                     done,
    output logic                     busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int BIT_W = $clog2(PAT_W);

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               led_q, led_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic [IDX_W-1:0]   win;
    logic [IDX_W-1:0]   rr_next;
    logic [BIT_W-1:0]   bit_sel;
    logic               found;
    logic               abort;
    logic               tick;
    int                 j;

    // First active requester at or after rr_q, wrapping modulo NUM_REQ.
    always_comb begin
        win   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(rr_q) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!found && req[j]) begin
                found = 1'b1;
                win   = IDX_W'(j);
            end
        end
    end

    assign rr_next = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);

`ifdef LED_ARB_ABORT_EN
    assign abort = (state_q == ST_PLAY) && !req[idx_q];
`else
    assign abort = 1'b0;
`endif

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk    (sys_clk),
        .rst    (sys_rst),
        .enable ((state_q == ST_PLAY) && !abort),
        .tick   (tick)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        pat_d   = pat_q;
        bit_d   = bit_q;
        rr_d    = rr_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                gnt_d = '0;
                if (|req) begin
                    state_d    = ST_PLAY;
                    gnt_d[win] = 1'b1;
                    idx_d      = win;
                    pat_d      = pattern[int'(win)*PAT_W +: PAT_W];
                    bit_d      = '0;
                end
            end
            ST_PLAY: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    rr_d    = rr_next;
                end else if (tick) begin
                    if (bit_q == BIT_W'(PAT_W - 1)) begin
                        state_d = ST_DONE;
                        gnt_d   = '0;
                        rr_d    = rr_next;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
        // LED is registered from next-state so it is valid on the first PLAY cycle.
        bit_sel = BIT_W'(PAT_W - 1) - bit_d;
        led_d   = (state_d == ST_PLAY) ? pat_d[bit_sel] : 1'b0;
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            pat_q   <= '0;
            bit_q   <= '0;
            rr_q    <= '0;
            idx_q   <= '0;
            led_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            pat_q   <= pat_d;
            bit_q   <= bit_d;
            rr_q    <= rr_d;
            idx_q   <= idx_d;
            led_q   <= led_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt     = gnt_q;
    assign led_out = led_q;
    assign done    = done_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_led_arbiter.sv
// Scoreboard bench for led_arbiter: stimulus queues expected grant/done/abort events, a monitor checks them.
module tb_led_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int TICK_DIV = 4;
    localparam int PAT_W    = 8;
    localparam int PLAY_LEN = PAT_W * TICK_DIV;

    typedef enum int {EV_GRANT, EV_DONE, EV_ABORT} ev_t;
    typedef struct {
        ev_t              kind;
        logic [NUM_REQ-1:0] gnt;
        logic [PAT_W-1:0] pat;
        int               gap;
    } exp_t;

    logic                     sys_clk = 1'b0;
    logic                     sys_rst = 1'b1;
    logic [NUM_REQ-1:0]       req     = '0;
    logic [NUM_REQ*PAT_W-1:0] pattern = '0;
    logic [NUM_REQ-1:0]       gnt;
    logic                     led_out;
    logic                     done;
    logic                     busy;

    led_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .TICK_DIV (TICK_DIV),
        .PAT_W    (PAT_W)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .req     (req),
        .pattern (pattern),
        .gnt     (gnt),
        .led_out (led_out),
        .done    (done),
        .busy    (busy)
    );

    always #5 sys_clk = ~sys_clk;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    function automatic void push_ev(input ev_t k, input logic [NUM_REQ-1:0] g,
                                    input logic [PAT_W-1:0] p, input int gap);
        exp_t e;
        e.kind = k; e.gnt = g; e.pat = p; e.gap = gap;
        exp_q.push_back(e);
    endfunction

    task automatic wait_grant(input string name);
        bit got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(posedge sys_clk); #1;
            if (gnt != '0) got = 1'b1;
        end
        check({name, "_grant_seen"}, 32'(got), 32'd1);
    endtask

    task automatic wait_done(input string name);
        bit got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(posedge sys_clk); #1;
            if (done) got = 1'b1;
        end
        check({name, "_done_seen"}, 32'(got), 32'd1);
    endtask

    // Monitor: reconstructs each played pattern from led_out and checks events against the queue.
    bit                 in_play   = 1'b0;
    int                 c_play    = 0;
    int                 since_done = 0;
    bit                 steady    = 1'b1;
    logic [PAT_W-1:0]   obs       = '0;
    logic [NUM_REQ-1:0] play_gnt  = '0;

    always @(negedge sys_clk) begin
        exp_t e;
        bit   ok;
        int   bidx;
        if (sys_rst) begin
            in_play = 1'b0;
        end else begin
            since_done++;
            if (done) begin
                n_cmp++;
                if (!in_play || exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL done_event: unexpected done (in_play=%0d queued=%0d)", in_play, exp_q.size());
                end else begin
                    e  = exp_q.pop_front();
                    ok = (e.kind == EV_DONE) && (obs == e.pat) && (c_play == PLAY_LEN) && steady
                         && !led_out && (gnt == '0) && busy;
                    if (!ok) begin
                        n_fail++;
                        $display("FAIL done_event: kind=%0d pat=%h len=%0d steady=%0d led=%b gnt=%b busy=%b, want kind=%0d pat=%h len=%0d steady=1 led=0 gnt=0 busy=1",
                                 EV_DONE, obs, c_play, steady, led_out, gnt, busy, e.kind, e.pat, PLAY_LEN);
                    end
                end
                in_play    = 1'b0;
                since_done = 0;
            end else if (in_play && gnt == '0) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL abort_event: unexpected early release after %0d cycles", c_play);
                end else begin
                    e  = exp_q.pop_front();
                    ok = (e.kind == EV_ABORT) && !led_out && !busy;
                    if (!ok) begin
                        n_fail++;
                        $display("FAIL abort_event: kind=%0d led=%b busy=%b after %0d cycles, want kind=%0d led=0 busy=0",
                                 EV_ABORT, led_out, busy, c_play, e.kind);
                    end
                end
                in_play = 1'b0;
            end else if (!in_play && gnt != '0) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL grant_event: unexpected grant %b", gnt);
                end else begin
                    e  = exp_q.pop_front();
                    ok = (e.kind == EV_GRANT) && (gnt == e.gnt) && busy && (e.gap < 0 || since_done == e.gap);
                    if (!ok) begin
                        n_fail++;
                        $display("FAIL grant_event: kind=%0d gnt=%b busy=%b gap=%0d, want kind=%0d gnt=%b busy=1 gap=%0d",
                                 EV_GRANT, gnt, busy, since_done, e.kind, e.gnt, e.gap);
                    end
                end
                in_play  = 1'b1;
                play_gnt = gnt;
                c_play   = 0;
                obs      = '0;
                steady   = 1'b1;
            end
            if (in_play && gnt != '0) begin
                if (gnt != play_gnt || c_play >= PLAY_LEN) begin
                    steady = 1'b0;
                end else begin
                    bidx = c_play / TICK_DIV;
                    if (c_play % TICK_DIV == 0) obs[PAT_W-1-bidx] = led_out;
                    else if (led_out != obs[PAT_W-1-bidx]) steady = 1'b0;
                end
                c_play++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, held across clock edges.
        repeat (2) @(posedge sys_clk);
        #1;
        check("reset_outputs", {gnt, led_out, done, busy}, '0);
        sys_rst = 1'b0;

        // Idle: no requests for 100 cycles.
        for (int k = 0; k < 100; k++) begin
            @(negedge sys_clk);
            check("idle", {gnt, led_out, done, busy, 8'(dut.u_tick.cnt_q)}, '0);
        end

        // Single request, A5 plays MSB first.
        @(posedge sys_clk); #1;
        pattern[0 +: PAT_W] = 8'hA5;
        push_ev(EV_GRANT, 4'b0001, '0, -1);
        push_ev(EV_DONE, '0, 8'hA5, -1);
        req = 4'b0001;
        @(posedge sys_clk); #1;
        check("single_grant_latency", gnt, 4'b0001);
        wait_done("single");
        req = '0;
        repeat (3) @(posedge sys_clk);

        // Pattern changes mid-play are ignored.
        #1;
        pattern[0 +: PAT_W] = 8'hFF;
        push_ev(EV_GRANT, 4'b0001, '0, -1);
        push_ev(EV_DONE, '0, 8'hFF, -1);
        req = 4'b0001;
        wait_grant("stable");
        repeat (8) @(posedge sys_clk);
        #1;
        pattern[0 +: PAT_W] = 8'h00;
        wait_done("stable");
        req = '0;
        repeat (3) @(posedge sys_clk);

        // Requester 0 drops its request during bit 2.
        #1;
        pattern[0 +: PAT_W] = 8'hC3;
        push_ev(EV_GRANT, 4'b0001, '0, -1);
`ifdef LED_ARB_ABORT_EN
        push_ev(EV_ABORT, '0, '0, -1);
`else
        push_ev(EV_DONE, '0, 8'hC3, -1);
`endif
        req = 4'b0001;
        wait_grant("abort");
        repeat (9) @(posedge sys_clk);
        #1;
        req = '0;
`ifdef LED_ARB_ABORT_EN
        @(posedge sys_clk); #1;
        check("abort_outputs", {gnt, led_out, done, busy}, '0);
`else
        wait_done("no_abort");
`endif
        repeat (3) @(posedge sys_clk);

        // Reset mid-cycle during bit 5, then lowest active index wins.
        #1;
        pattern = {8'h81, 8'hF0, 8'h3C, 8'h5A};
        push_ev(EV_GRANT, 4'b0001, '0, -1);
        req = 4'b0001;
        wait_grant("rst_mid");
        repeat (21) @(posedge sys_clk);
        #3;
        sys_rst = 1'b1;
        req     = 4'b1010;
        #1;
        check("async_reset_outputs", {gnt, led_out, done, busy}, '0);
        push_ev(EV_GRANT, 4'b0010, '0, -1);
        push_ev(EV_DONE, '0, 8'h3C, -1);
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        @(posedge sys_clk); #1;
        check("post_reset_grant", gnt, 4'b0010);
        wait_done("rst_mid");
        req = '0;
        repeat (3) @(posedge sys_clk);

        // Fresh reset so round-robin starts from requester 0.
        #1;
        sys_rst = 1'b1;
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        push_ev(EV_GRANT, 4'b0001, '0, -1);
        push_ev(EV_DONE, '0, 8'h5A, -1);
        push_ev(EV_GRANT, 4'b0010, '0, 2);
        push_ev(EV_DONE, '0, 8'h3C, -1);
        push_ev(EV_GRANT, 4'b0100, '0, 2);
        push_ev(EV_DONE, '0, 8'hF0, -1);
        push_ev(EV_GRANT, 4'b1000, '0, 2);
        push_ev(EV_DONE, '0, 8'h81, -1);
        push_ev(EV_GRANT, 4'b0001, '0, 2);
        push_ev(EV_DONE, '0, 8'h5A, -1);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) wait_done("rr");
        req = '0;

        repeat (10) @(posedge sys_clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
